// File: rtl/pbvi_pkg.sv
// Shared PBVI constants, the sweep FSM state type and default controller sizing.
// Used by the sweep controller and by the step1/step2/step3 datapath instances.
package pbvi_pkg;

    localparam int ITER_W_DEF  = 8;
    localparam int TMO_W_DEF   = 8;
    localparam int TMO_CYC_DEF = 64;

    localparam int N_BELIEF = 16;
    localparam int N_ALPHA  = 16;
    localparam int N_ACTION = 3;
    localparam int N_OBS    = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S1_GO,
        ST_S1_WAIT,
        ST_S2_GO,
        ST_S2_WAIT,
        ST_S3_GO,
        ST_S3_WAIT,
        ST_CHECK,
        ST_FINISH
    } sweep_state_t;

endpackage

// File: rtl/pbvi_sweep_ctrl_watchdog.sv
// Per-stage hang detector: counts enabled cycles since the last clear and saturates.
// tc is decoded from the count register, so it is valid the cycle the count reaches TMO_CYC-1.
module stage_watchdog #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TC_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/pbvi_sweep_ctrl.sv
// PBVI backup sweep sequencer: issues step1/2/3 enables in order, repeats up to iter_max or convergence.
// Enables are one cycle after the accepting edge; a stage hung for TMO_CYC cycles ends the run with err.
module pbvi_sweep_ctrl
    import pbvi_pkg::*;
#(
    parameter int ITER_W  = ITER_W_DEF,
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_max,
    input  logic              abort,
    input  logic              s1_done,
    input  logic              s2_done,
    input  logic              s3_done,
    input  logic              s3_conv,
    output logic              en_s1,
    output logic              en_s2,
    output logic              en_s3,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              converged,
    output logic [ITER_W-1:0] iter_idx
);

    sweep_state_t      state;
    sweep_state_t      nxt;
    logic [ITER_W-1:0] iter_max_q;
    logic              conv_q;

    logic wd_clr;
    logic wd_en;
    logic wd_tc;
    logic accept;
    logic set_err;
    logic set_conv;
    logic inc_idx;
    logic take_s3;

    stage_watchdog #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .en    (wd_en),
        .tc    (wd_tc)
    );

    always_comb begin
        nxt      = state;
        wd_clr   = 1'b0;
        wd_en    = 1'b0;
        accept   = 1'b0;
        set_err  = 1'b0;
        set_conv = 1'b0;
        inc_idx  = 1'b0;
        take_s3  = 1'b0;
        if ((state != ST_IDLE) && abort) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        accept = 1'b1;
                        nxt    = (iter_max == '0) ? ST_FINISH : ST_S1_GO;
                    end
                end
                ST_S1_GO: begin
                    wd_clr = 1'b1;
                    nxt    = ST_S1_WAIT;
                end
                // Timeout is tested before done: a done coinciding with the timeout is dropped.
                ST_S1_WAIT: begin
                    wd_en = 1'b1;
                    if (wd_tc) begin
                        set_err = 1'b1;
                        nxt     = ST_FINISH;
                    end else if (s1_done) begin
                        nxt = ST_S2_GO;
                    end
                end
                ST_S2_GO: begin
                    wd_clr = 1'b1;
                    nxt    = ST_S2_WAIT;
                end
                ST_S2_WAIT: begin
                    wd_en = 1'b1;
                    if (wd_tc) begin
                        set_err = 1'b1;
                        nxt     = ST_FINISH;
                    end else if (s2_done) begin
                        nxt = ST_S3_GO;
                    end
                end
                ST_S3_GO: begin
                    wd_clr = 1'b1;
                    nxt    = ST_S3_WAIT;
                end
                ST_S3_WAIT: begin
                    wd_en = 1'b1;
                    if (wd_tc) begin
                        set_err = 1'b1;
                        nxt     = ST_FINISH;
                    end else if (s3_done) begin
                        take_s3 = 1'b1;
                        nxt     = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (conv_q) begin
                        set_conv = 1'b1;
                        nxt      = ST_FINISH;
                    end else if (iter_idx == (iter_max_q - ITER_W'(1))) begin
                        nxt = ST_FINISH;
                    end else begin
                        inc_idx = 1'b1;
                        nxt     = ST_S1_GO;
                    end
                end
                ST_FINISH: nxt = ST_IDLE;
                default:   nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            iter_max_q <= '0;
            iter_idx   <= '0;
            err        <= 1'b0;
            converged  <= 1'b0;
            conv_q     <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                iter_max_q <= iter_max;
                iter_idx   <= '0;
                err        <= 1'b0;
                converged  <= 1'b0;
                conv_q     <= 1'b0;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (set_conv) begin
                converged <= 1'b1;
            end
            if (inc_idx) begin
                iter_idx <= iter_idx + 1'b1;
            end
            // s3_conv is only meaningful alongside s3_done, so sample it on that edge alone.
            if (take_s3) begin
                conv_q <= s3_conv;
            end
        end
    end

    assign en_s1 = (state == ST_S1_GO);
    assign en_s2 = (state == ST_S2_GO);
    assign en_s3 = (state == ST_S3_GO);
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_FINISH);

endmodule

// File: tb/tb_pbvi_sweep_ctrl.sv
// Directed bench for pbvi_sweep_ctrl: a stage responder drives the done inputs,
// and a scoreboard of expected enables and completion records is checked on each DUT pulse.
module tb_pbvi_sweep_ctrl;
    import pbvi_pkg::*;

    localparam int ITER_W  = 8;
    localparam int TMO_W   = 8;
    localparam int TMO_CYC = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic [ITER_W-1:0] iter_max = '0;
    logic              abort    = 1'b0;
    logic              s1_done  = 1'b0;
    logic              s2_done  = 1'b0;
    logic              s3_done  = 1'b0;
    logic              s3_conv  = 1'b0;
    logic              en_s1, en_s2, en_s3, busy, done, err, converged;
    logic [ITER_W-1:0] iter_idx;

    pbvi_sweep_ctrl #(
        .ITER_W  (ITER_W),
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .iter_max  (iter_max),
        .abort     (abort),
        .s1_done   (s1_done),
        .s2_done   (s2_done),
        .s3_done   (s3_done),
        .s3_conv   (s3_conv),
        .en_s1     (en_s1),
        .en_s2     (en_s2),
        .en_s3     (en_s3),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .converged (converged),
        .iter_idx  (iter_idx)
    );

    typedef struct packed {
        logic [1:0] stage;
        logic [7:0] idx;
    } en_exp_t;

    typedef struct packed {
        logic       conv;
        logic       err;
        logic [7:0] idx;
    } done_exp_t;

    en_exp_t   exp_en[$];
    done_exp_t exp_done[$];

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;

    // Responder knobs: autoN answers enN with a done in the first WAIT cycle.
    logic       auto1 = 1'b1, auto2 = 1'b1, auto3 = 1'b1;
    logic       s1_hold  = 1'b0;
    logic       conv_en  = 1'b0;
    logic [7:0] conv_idx = '0;
    logic       pend1 = 1'b0, pend2 = 1'b0, pend3 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_sweeps(input int n);
        for (int i = 0; i < n; i++) begin
            exp_en.push_back({2'd1, 8'(i)});
            exp_en.push_back({2'd2, 8'(i)});
            exp_en.push_back({2'd3, 8'(i)});
        end
    endtask

    task automatic push_done(input logic c, input logic e, input int idx);
        exp_done.push_back({c, e, 8'(idx)});
    endtask

    // Called at posedge+#1; returns with the accepting edge passed (cycle 1 = first cycle after it).
    task automatic start_run(input int mx);
        iter_max = ITER_W'(mx);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int from_cyc, output int cyc);
        cyc = from_cyc;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) check("done_wait_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic step_idle(input string tag, input int exp_cnt);
        @(posedge clk);
        #1;
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check({tag, "_done_count"}, done_cnt, exp_cnt);
    endtask

    always @(posedge clk) begin
        #1;
        s1_done = (auto1 && pend1) || s1_hold;
        s2_done = auto2 && pend2;
        s3_done = auto3 && pend3;
        s3_conv = s3_done && conv_en && (iter_idx == conv_idx);
        pend1   = en_s1;
        pend2   = en_s2;
        pend3   = en_s3;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int        code;
            en_exp_t   e;
            done_exp_t d;
            code = en_s1 ? 1 : en_s2 ? 2 : en_s3 ? 3 : 0;
            if (code != 0) begin
                if (exp_en.size() == 0) begin
                    check("en_unexpected", code, 0);
                end else begin
                    e = exp_en.pop_front();
                    check("en_stage", code, {30'b0, e.stage});
                    check("en_iter_idx", {24'b0, iter_idx}, {24'b0, e.idx});
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    check("done_unexpected", {31'b0, done}, 32'd0);
                end else begin
                    d = exp_done.pop_front();
                    check("done_converged", {31'b0, converged}, {31'b0, d.conv});
                    check("done_err", {31'b0, err}, {31'b0, d.err});
                    check("done_iter_idx", {24'b0, iter_idx}, {24'b0, d.idx});
                    check("done_busy", {31'b0, busy}, 32'd1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL tb_global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int c;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {25'b0, en_s1, en_s2, en_s3, busy, done, err, converged}, 32'd0);
        check("reset_iter_idx", {24'b0, iter_idx}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three full sweeps at minimum latency, no convergence.
        push_sweeps(3);
        push_done(1'b0, 1'b0, 2);
        start_run(3);
        check("t1_en_s1_cycle1", {31'b0, en_s1}, 32'd1);
        check("t1_busy_cycle1", {31'b0, busy}, 32'd1);
        wait_done(1, c);
        check("t1_done_cycle", c, 22);
        step_idle("t1", 1);

        // Convergence reported in the second sweep.
        conv_en  = 1'b1;
        conv_idx = 8'd1;
        push_sweeps(2);
        push_done(1'b1, 1'b0, 1);
        start_run(10);
        wait_done(1, c);
        check("t2_done_cycle", c, 15);
        step_idle("t2", 2);
        conv_en = 1'b0;

        // Step2 hangs: watchdog fires 64 cycles after S2_WAIT is entered (cycle 4).
        auto2 = 1'b0;
        exp_en.push_back({2'd1, 8'd0});
        exp_en.push_back({2'd2, 8'd0});
        push_done(1'b0, 1'b1, 0);
        start_run(2);
        wait_done(1, c);
        check("t3_done_cycle", c, 4 + TMO_CYC);
        step_idle("t3", 3);
        check("t3_err_sticky", {31'b0, err}, 32'd1);
        auto2 = 1'b1;

        // Zero iterations: straight to FINISH, flags cleared, no enables.
        push_done(1'b0, 1'b0, 0);
        start_run(0);
        wait_done(1, c);
        check("t5_done_cycle", c, 1);
        step_idle("t5", 4);

        // Abort while waiting in S1_WAIT of the first sweep.
        auto1 = 1'b0;
        exp_en.push_back({2'd1, 8'd0});
        start_run(5);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("t4_abort_busy", {31'b0, busy}, 32'd0);
        check("t4_abort_flags", {30'b0, err, converged}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_abort_no_done", done_cnt, 4);
        auto1 = 1'b1;
        push_sweeps(1);
        push_done(1'b0, 1'b0, 0);
        start_run(1);
        wait_done(1, c);
        check("t4_clean_done_cycle", c, 8);
        step_idle("t4", 5);

        // s1_done held high throughout, and a start pulse with a new limit mid-run.
        s1_hold = 1'b1;
        push_sweeps(1);
        push_done(1'b0, 1'b0, 0);
        start_run(1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        iter_max = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(4, c);
        check("t6_done_cycle", c, 8);
        s1_hold = 1'b0;
        step_idle("t6", 6);

        // Reset asserted while step3 is outstanding.
        auto3 = 1'b0;
        push_sweeps(1);
        start_run(2);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("t7_in_s3_wait", 32'(dut.state), 32'(ST_S3_WAIT));
        rst_n = 1'b0;
        #1;
        check("t7_rst_outputs", {25'b0, en_s1, en_s2, en_s3, busy, done, err, converged}, 32'd0);
        check("t7_rst_iter_idx", {24'b0, iter_idx}, 32'd0);
        check("t7_rst_state", 32'(dut.state), 32'(ST_IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        auto3 = 1'b1;
        @(posedge clk);
        #1;
        push_sweeps(2);
        push_done(1'b0, 1'b0, 1);
        start_run(2);
        wait_done(1, c);
        check("t7_recover_done_cycle", c, 15);
        step_idle("t7", 7);

        check("exp_en_drained", exp_en.size(), 0);
        check("exp_done_drained", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
